// File: rtl/i2c_ram_arbiter.sv
// Two-port arbiter in front of the single-port I2C register RAM: round-robin
// between slave FSM and local host, lock-based ownership with bounded hold.
module i2c_ram_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              slv_req,
  input  logic              slv_wr,
  input  logic              slv_lock,
  input  logic [ADDR_W-1:0] slv_addr,
  input  logic [DATA_W-1:0] slv_wdata,
  output logic              slv_gnt,
  output logic [DATA_W-1:0] slv_rdata,
  output logic              slv_rvalid,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, OWN_SLV, OWN_HOST} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;        // 0 = slave won last, 1 = host
  logic [HW-1:0]     hold_q, hold_d;
  logic              pend_q, pend_d;
  logic              pend_port_q, pend_port_d;
  logic [DATA_W-1:0] slv_rdata_q, slv_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              gs, gh, win_lock, own_acc, other_req;

  // Grant decode from registered state and live requests.
  always_comb begin
    gs = 1'b0;
    gh = 1'b0;
    if (!reset_in) begin
      unique case (state_q)
        IDLE: begin
          if (slv_req && (!host_req || last_q)) gs = 1'b1;
          else if (host_req)                    gh = 1'b1;
        end
        OWN_SLV: begin
          if (slv_req) begin
            if (hold_q == HOLD_LIMIT && host_req) gh = 1'b1;
            else                                  gs = 1'b1;
          end
        end
        OWN_HOST: begin
          if (host_req) begin
            if (hold_q == HOLD_LIMIT && slv_req) gs = 1'b1;
            else                                 gh = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = hold_q;
    win_lock  = gh ? host_lock : slv_lock;
    own_acc   = (state_q == OWN_SLV && gs) || (state_q == OWN_HOST && gh);
    other_req = (state_q == OWN_SLV) ? host_req : slv_req;
    if (gs || gh) begin
      last_d = gh;
      if (own_acc) begin
        if (!win_lock) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = other_req ? hold_q + 1'b1 : '0;
        end
      end else if (win_lock) begin
        // Fresh acquisition (from IDLE or a forced hand-over)
        state_d = gh ? OWN_HOST : OWN_SLV;
        hold_d  = HW'(1);
      end else begin
        state_d = IDLE;
        hold_d  = '0;
      end
    end else if (state_q != IDLE) begin
      state_d = IDLE;
      hold_d  = '0;
    end
  end

  always_comb begin
    pend_d       = (gs && !slv_wr) || (gh && !host_wr);
    pend_port_d  = gh;
    slv_rvalid   = pend_q && !pend_port_q && !reset_in;
    host_rvalid  = pend_q &&  pend_port_q && !reset_in;
    slv_rdata_d  = slv_rvalid  ? ram_rdata : slv_rdata_q;
    host_rdata_d = host_rvalid ? ram_rdata : host_rdata_q;
    slv_rdata    = reset_in ? '0 : slv_rdata_d;
    host_rdata   = reset_in ? '0 : host_rdata_d;
  end

  assign slv_gnt   = gs;
  assign host_gnt  = gh;
  assign ram_wr_en = (gs && slv_wr)  || (gh && host_wr);
  assign ram_rd_en = (gs && !slv_wr) || (gh && !host_wr);
  assign ram_addr  = gh ? host_addr  : slv_addr;
  assign ram_wdata = gh ? host_wdata : slv_wdata;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      hold_q       <= '0;
      pend_q       <= 1'b0;
      pend_port_q  <= 1'b0;
      slv_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      hold_q       <= hold_d;
      pend_q       <= pend_d;
      pend_port_q  <= pend_port_d;
      slv_rdata_q  <= slv_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end
endmodule

// File: tb/tb_i2c_ram_arbiter.sv
// Scoreboard bench for i2c_ram_arbiter with a behavioural 128x8 RAM attached.
module tb_i2c_ram_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic       slv_req = 0, slv_wr = 0, slv_lock = 0;
  logic [6:0] slv_addr = '0;
  logic [7:0] slv_wdata = '0;
  logic       host_req = 0, host_wr = 0, host_lock = 0;
  logic [6:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       slv_gnt, slv_rvalid, host_gnt, host_rvalid;
  logic [7:0] slv_rdata, host_rdata;
  logic       ram_wr_en, ram_rd_en;
  logic [6:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = '0;

  logic [7:0] mem [128];
  logic [7:0] ref_mem [128];

  typedef struct packed { logic port; logic [7:0] data; } ret_t;
  ret_t sb [$];

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  i2c_ram_arbiter #(.ADDR_W(7), .DATA_W(8), .MAX_HOLD(4)) dut (
    .clock_in(clk), .reset_in(rst),
    .slv_req(slv_req), .slv_wr(slv_wr), .slv_lock(slv_lock),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_gnt(slv_gnt),
    .slv_rdata(slv_rdata), .slv_rvalid(slv_rvalid),
    .host_req(host_req), .host_wr(host_wr), .host_lock(host_lock),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_wdata;
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_slv(input logic req, input logic wr, input logic lock,
                         input logic [6:0] a, input logic [7:0] d);
    slv_req = req; slv_wr = wr; slv_lock = lock; slv_addr = a; slv_wdata = d;
  endtask

  task automatic set_host(input logic req, input logic wr, input logic lock,
                          input logic [6:0] a, input logic [7:0] d);
    host_req = req; host_wr = wr; host_lock = lock; host_addr = a; host_wdata = d;
  endtask

  // One cycle: inputs were applied just after the previous edge; sample mid-cycle.
  task automatic cyc(input logic es, input logic eh);
    ret_t e;
    #4;
    chk("slv_gnt", slv_gnt, es);
    chk("host_gnt", host_gnt, eh);
    chk("ram_wr_en", ram_wr_en, (es && slv_wr) || (eh && host_wr));
    chk("ram_rd_en", ram_rd_en, (es && !slv_wr) || (eh && !host_wr));
    if (es) chk("ram_addr_s", ram_addr, slv_addr);
    if (eh) chk("ram_addr_h", ram_addr, host_addr);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("slv_rvalid", slv_rvalid, !e.port);
      chk("host_rvalid", host_rvalid, e.port);
      if (e.port) chk("host_rdata", host_rdata, e.data);
      else        chk("slv_rdata", slv_rdata, e.data);
    end else begin
      chk("slv_rvalid_idle", slv_rvalid, 1'b0);
      chk("host_rvalid_idle", host_rvalid, 1'b0);
    end
    if (es && slv_req) begin
      if (slv_wr) ref_mem[slv_addr] = slv_wdata;
      else        sb.push_back('{port: 1'b0, data: ref_mem[slv_addr]});
    end
    if (eh && host_req) begin
      if (host_wr) ref_mem[host_addr] = host_wdata;
      else         sb.push_back('{port: 1'b1, data: ref_mem[host_addr]});
    end
    @(posedge clk); #1;
  endtask

  // Reset cycle with both ports requesting: nothing may leak out.
  task automatic rst_cyc();
    rst = 1'b1;
    #4;
    chk("rst_slv_gnt", slv_gnt, 1'b0);
    chk("rst_host_gnt", host_gnt, 1'b0);
    chk("rst_wr_en", ram_wr_en, 1'b0);
    chk("rst_rd_en", ram_rd_en, 1'b0);
    chk("rst_slv_rvalid", slv_rvalid, 1'b0);
    chk("rst_host_rvalid", host_rvalid, 1'b0);
    chk("rst_slv_rdata", slv_rdata, 8'h00);
    chk("rst_host_rdata", host_rdata, 8'h00);
    sb.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    @(posedge clk); #1;
    set_slv(1, 0, 1, 7'h01, 8'h00);
    set_host(1, 1, 1, 7'h02, 8'h11);
    rst_cyc();
    rst_cyc();
    rst = 1'b0;

    // Slave write, host read of the same word, then address 7F write.
    set_slv(1, 1, 0, 7'h10, 8'hA5);
    set_host(0, 0, 0, 7'h00, 8'h00);
    cyc(1, 0);
    set_slv(0, 0, 0, 7'h00, 8'h00);
    set_host(1, 0, 0, 7'h10, 8'h00);
    cyc(0, 1);
    set_host(1, 1, 0, 7'h7F, 8'h3C);
    cyc(0, 1);
    set_host(0, 0, 0, 7'h00, 8'h00);
    cyc(0, 0);

    // Both ports reading continuously after reset: strict alternation.
    rst_cyc();
    rst = 1'b0;
    set_slv(1, 0, 0, 7'h10, 8'h00);
    set_host(1, 0, 0, 7'h7F, 8'h00);
    for (int i = 0; i < 6; i++) cyc(i % 2 == 0, i % 2 == 1);
    set_slv(0, 0, 0, 7'h00, 8'h00);
    set_host(0, 0, 0, 7'h00, 8'h00);
    cyc(0, 0);

    // Host lock: unbounded while slave idle, exactly 4 grants once slave waits.
    set_host(1, 0, 1, 7'h7F, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0, 1);
    set_slv(1, 0, 0, 7'h10, 8'h00);
    for (int i = 0; i < 4; i++) cyc(0, 1);
    cyc(1, 0);
    set_slv(0, 0, 0, 7'h00, 8'h00);
    for (int i = 0; i < 6; i++) cyc(0, 1);
    set_host(0, 0, 0, 7'h00, 8'h00);
    cyc(0, 0);

    // Slave lock then one cycle without req: no grant, host next.
    set_slv(1, 1, 1, 7'h20, 8'h5A);
    cyc(1, 0);
    set_slv(0, 0, 1, 7'h20, 8'h00);
    set_host(1, 0, 0, 7'h20, 8'h00);
    cyc(0, 0);
    cyc(0, 1);
    set_host(0, 0, 0, 7'h00, 8'h00);
    set_slv(0, 0, 0, 7'h00, 8'h00);
    cyc(0, 0);

    // Slave read of 7F, reset right after: no return, slave wins first tie.
    set_slv(1, 0, 0, 7'h7F, 8'h00);
    cyc(1, 0);
    set_host(1, 0, 0, 7'h10, 8'h00);
    rst_cyc();
    rst_cyc();
    rst = 1'b0;
    cyc(1, 0);
    cyc(0, 1);
    set_slv(0, 0, 0, 7'h00, 8'h00);
    set_host(0, 0, 0, 7'h00, 8'h00);
    cyc(0, 0);
    cyc(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_ram_arbiter.md
Name: i2c_ram_arbiter

Overview:
- Shares the single-port 128x8 I2C register RAM between two requesters: the I2C slave FSM port (slv_*) and a local host port (host_*).
- Sits between both requesters and the RAM's wr_en/rd_en/addr/data pins, in the same clock domain as the RAM.
- Provides round-robin arbitration, lock-based ownership with a bounded hold time, and routes read data back with a valid strobe.

Parameters:
- ADDR_W, 7, RAM word address width (128 locations)
- DATA_W, 8, data width
- MAX_HOLD, 4, maximum consecutive locked grants to one owner while the other requester is waiting (minimum 1)

Ports:
- clock_in  input  1  RAM/arbiter clock; all state updates on the rising edge
- reset_in  input  1  synchronous active-high reset
- slv_req  input  1  slave command request
- slv_wr  input  1  1 = write, 0 = read
- slv_lock  input  1  request to retain ownership after this access
- slv_addr  input  ADDR_W  slave word address
- slv_wdata  input  DATA_W  slave write data
- slv_gnt  output  1  slave command accepted at the next rising edge
- slv_rdata  output  DATA_W  read data to slave
- slv_rvalid  output  1  slv_rdata valid
- host_req, host_wr, host_lock, host_addr, host_wdata, host_gnt, host_rdata, host_rvalid: same directions, widths and meanings for the host port
- ram_wr_en  output  1  to RAM wr_en
- ram_rd_en  output  1  to RAM rd_en
- ram_addr  output  ADDR_W  to RAM addr
- ram_wdata  output  DATA_W  to RAM data_in
- ram_rdata  input  DATA_W  from RAM data_out (registered; valid one cycle after the rd_en edge)

Behaviour:
- Reset:
  - While reset_in = 1, all gnt, rvalid, ram_wr_en and ram_rd_en outputs are 0.
  - state = IDLE, last = HOST (so the slave wins the first tie), hold_cnt = 0.
  - ram_addr/ram_wdata are don't-care; rdata outputs are 0.
- Grant:
  - gnt is combinational from the registered state plus the current req inputs.
  - A command is accepted at the rising edge where req & gnt = 1.
  - At most one gnt is high in any cycle.
  - The requester holds req, wr, addr, wdata and lock stable until the edge of acceptance.
  - req may stay high for back-to-back commands; a new command is presented in the cycle after acceptance.
- RAM drive:
  - ram_* is a combinational mux of the granted port.
  - ram_wr_en = gnt & wr; ram_rd_en = gnt & ~wr.
  - With no grant, both enables are 0.
- States:
  - IDLE:
    - Only one req: grant it.
    - Both req: grant the port != last.
    - On acceptance: last <= winner.
    - If lock is set at acceptance: go to OWN_SLV or OWN_HOST, hold_cnt <= 1.
  - OWN_x (x owns):
    - Only x is granted while x_req = 1 and the hold limit has not been hit.
    - On acceptance with lock: hold_cnt increments, but only if the other port is requesting; otherwise hold_cnt is cleared to 0.
    - On acceptance with lock = 0: go to IDLE.
    - If x_req = 0 in a cycle: go to IDLE and release ownership (no grant that cycle to either port).
    - Forced release: if hold_cnt = MAX_HOLD and the other port is requesting, x is not granted. The other port is granted in that same cycle, with normal IDLE-style acceptance (last updated, its own lock honoured).
  - A lock asserted without req is ignored.
- Read return:
  - When a read is accepted at edge E, the read data is returned in the cycle after E: rvalid pulses 1 for one cycle to the accepting port, with rdata = ram_rdata.
  - Implementation: a registered 1-bit pending flag plus a port ID.
  - The non-owning port's rdata holds its last value.
- Writes produce no return strobe.
- Throughput: one access per cycle; read latency is 1 cycle from acceptance to rvalid.
- Simultaneous read-return and new acceptance in the same cycle are legal and independent.
- Reset asserted mid-operation clears the pending read: no rvalid is issued after reset, and no RAM enable is asserted during reset.
- Address wrap: addresses are ADDR_W bits, with no range check; 7'h7F is a valid location.

Test Plan:
- Reset, then slv write addr 7'h10 = 8'hA5, then host read 7'h10 -> slv_gnt accepted at the first edge; host_rvalid = 1 with host_rdata = 8'hA5 one cycle after the host read acceptance; slv_rvalid stays 0.
- Both ports request reads continuously after reset, lock = 0 -> grants alternate slv, host, slv, host; every access returns rvalid to the correct port 1 cycle later.
- Host holds lock = 1 with continuous reqs while slv requests, MAX_HOLD = 4 -> host gets exactly 4 consecutive grants, then slv_gnt = 1; when slv is idle, host keeps its grant indefinitely.
- Slave read of 7'h7F accepted, reset_in asserted in the following cycle -> slv_rvalid stays 0, ram_wr_en/ram_rd_en = 0 during reset; slave wins the first tie after reset.
- Slave acquires lock, then drops req for one cycle while host requests -> no grant in that cycle, state returns to IDLE, and host is granted in the next cycle.
